// File: rtl/present_pkg.sv
// present_pkg: shared widths, S-box table and FSM state type for the PRESENT-80 key schedule
package present_pkg;
  localparam int KEY_W = 80;
  localparam int RK_W = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int IDX_W = 6;
  localparam logic [15:0][3:0] SBOX = {4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
                                       4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC};
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction
endpackage

// File: rtl/present_key_schedule_if.sv
// present_key_schedule_if: key load request and round-key valid/ready stream
interface present_key_schedule_if;
  import present_pkg::*;
  logic [KEY_W-1:0] key_in;
  logic key_load;
  logic busy;
  logic [RK_W-1:0] rk_out;
  logic [IDX_W-1:0] rk_idx;
  logic rk_valid;
  logic rk_ready;
  logic done;
  modport master (input key_in, key_load, rk_ready, output busy, rk_out, rk_idx, rk_valid, done);
  modport slave (output key_in, key_load, rk_ready, input busy, rk_out, rk_idx, rk_valid, done);
endinterface

// File: rtl/present_key_update.sv
// present_key_update: one PRESENT-80 key-register update (rotate, S-box, round-counter xor)
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       rc,
  output logic [KEY_W-1:0] next_key
);
  logic [KEY_W-1:0] rot;
  // left rotate by 61, substitute the top nibble, fold in the round counter
  always_comb begin
    rot = {key[18:0], key[79:19]};
    next_key = {sbox4(rot[79:76]), rot[75:20], rot[19:15] ^ rc, rot[14:0]};
  end
endmodule

// File: rtl/present_key_schedule.sv
// present_key_schedule: latches an 80-bit key and streams round keys K1..K32 over valid/ready
module present_key_schedule
  import present_pkg::*;
(
  input logic clk,
  input logic rst,
  present_key_schedule_if.master bus
);
  state_t state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [IDX_W-1:0] idx;
  logic done_r, hs, last, load;
  present_key_update u_upd (.key(key_reg), .rc(idx[4:0]), .next_key(key_nxt));
  // handshake decode and next state; the final handshake returns to IDLE
  always_comb begin
    hs = state == ISSUE && bus.rk_ready;
    last = idx == IDX_W'(NUM_ROUNDS + 1);
    load = state == IDLE && bus.key_load;
    state_nxt = state == IDLE ? (bus.key_load ? ISSUE : IDLE) : (hs && last ? IDLE : ISSUE);
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // key register, index and done pulse; K32 is issued without a further update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_reg <= '0;
      idx <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= hs && last;
      if (load) begin
        key_reg <= bus.key_in;
        idx <= IDX_W'(1);
      end else if (hs && !last) begin
        key_reg <= key_nxt;
        idx <= idx + 1'b1;
      end
    end
  assign bus.busy = state == ISSUE;
  assign bus.rk_valid = state == ISSUE;
  assign bus.rk_out = key_reg[79:16];
  assign bus.rk_idx = idx;
  assign bus.done = done_r;
endmodule

// File: tb/tb_present_key_schedule.sv
// tb_present_key_schedule: scoreboard bench for the PRESENT-80 round-key streamer
module tb_present_key_schedule;
  logic clk, rst;
  logic rand_ready;
  present_key_schedule_if bus ();
  present_key_schedule dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_checks, n_fail;
  int cyc, hs_cyc, n_valid, n_done, last_idx;
  logic stalled;
  logic [69:0] held;
  logic [69:0] q[$];
  logic [63:0] obs[32];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t = 64'h21748FE3DA09B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [79:0] upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r = (k << 61) | (k >> 19);
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic void push_stream(input logic [79:0] k0);
    logic [79:0] k = k0;
    for (int i = 1; i <= 32; i++) begin
      q.push_back({6'(i), k[79:16]});
      if (i < 32) k = upd(k, 5'(i));
    end
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [63:0] s = pt, p;
    for (int r = 0; r < 31; r++) begin
      s = s ^ obs[r];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
      p[63] = s[63];
      for (int b = 0; b < 63; b++) p[(b * 16) % 63] = s[b];
      s = p;
    end
    return s ^ obs[31];
  endfunction

  // consumer ready: always high, or random back-pressure
  initial begin
    bus.rk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // monitor: scoreboard pops on handshakes, stall stability, done timing
  initial begin
    cyc = 0;
    stalled = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stalled = 0;
        continue;
      end
      if (bus.done) begin
        n_done++;
        check("done_excl_valid", 80'(bus.rk_valid), 80'(0));
        check("done_gap", 80'(cyc), 80'(hs_cyc + 1));
      end
      if (bus.rk_valid) begin
        if (stalled) check("stall_stable", {bus.rk_idx, bus.rk_out}, held);
        if (bus.rk_ready) begin
          if (q.size() == 0) check("sb_underflow", 80'(q.size()), 80'(1));
          else check("round_key", {bus.rk_idx, bus.rk_out}, q.pop_front());
          if (bus.rk_idx >= 1 && bus.rk_idx <= 32) obs[bus.rk_idx - 1] = bus.rk_out;
          n_valid++;
          last_idx = int'(bus.rk_idx);
          hs_cyc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {bus.rk_idx, bus.rk_out};
        end
      end
    end
  end

  task automatic load(input logic [79:0] k);
    @(negedge clk);
    bus.key_in = k;
    bus.key_load = 1'b1;
    push_stream(k);
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  task automatic wait_done();
    logic seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("done_timeout", 80'(seen), 80'(1));
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_done = 0;
    last_idx = 0;
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_fail = 0;
    rand_ready = 0;
    rst = 1;
    bus.key_in = '0;
    bus.key_load = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_valid", 80'(bus.rk_valid), 80'(0));
    check("rst_done", 80'(bus.done), 80'(0));
    check("rst_rk_out", 80'(bus.rk_out), 80'(0));
    check("rst_rk_idx", 80'(bus.rk_idx), 80'(0));
    rst = 0;

    clear_counts();
    load(80'h0);
    wait_done();
    check("busy_with_done", 80'(bus.busy), 80'(0));
    @(negedge clk);
    check("busy_after", 80'(bus.busy), 80'(0));
    check("valid_count", 80'(n_valid), 80'(32));
    check("last_idx", 80'(last_idx), 80'(32));
    check("done_count", 80'(n_done), 80'(1));
    check("k1_zero", 80'(obs[0]), 80'h0);
    check("k2_zero", 80'(obs[1]), 80'hC000000000000000);
    check("k3_zero", 80'(obs[2]), 80'h5000180000000001);
    check("cipher_zero", 80'(encrypt(64'h0)), 80'h5579C1387B228445);
    check("sb_empty_1", 80'(q.size()), 80'(0));

    rand_ready = 1;
    clear_counts();
    load(80'h0123456789ABCDEF0011);
    repeat (6) @(negedge clk);
    bus.key_in = 80'hFFFFFFFFFFFFFFFFFFFF;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    wait_done();
    @(negedge clk);
    check("bp_valid_count", 80'(n_valid), 80'(32));
    check("bp_done_count", 80'(n_done), 80'(1));
    check("sb_empty_2", 80'(q.size()), 80'(0));

    rand_ready = 0;
    load(80'hDEADBEEFCAFEF00D1234);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rk_idx == 6'd10;
    end
    check("idx10_timeout", 80'(seen), 80'(1));
    rst = 1;
    #1;
    check("mid_rst_valid", 80'(bus.rk_valid), 80'(0));
    check("mid_rst_busy", 80'(bus.busy), 80'(0));
    check("mid_rst_done", 80'(bus.done), 80'(0));
    q.delete();
    @(negedge clk);
    rst = 0;
    check("post_rst_idx", 80'(bus.rk_idx), 80'(0));
    clear_counts();
    load(80'h0);
    wait_done();
    check("restart_k1", 80'(obs[0]), 80'h0);
    check("sb_empty_3", 80'(q.size()), 80'(0));

    clear_counts();
    load(80'h13579BDF02468ACE1357);
    wait_done();
    bus.key_in = 80'h2468ACE013579BDF2468;
    bus.key_load = 1'b1;
    push_stream(80'h2468ACE013579BDF2468);
    @(negedge clk);
    bus.key_load = 1'b0;
    check("b2b_valid", 80'(bus.rk_valid), 80'(1));
    check("b2b_idx", 80'(bus.rk_idx), 80'(1));
    wait_done();
    @(negedge clk);
    check("b2b_done_count", 80'(n_done), 80'(2));
    check("sb_empty_4", 80'(q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/present_key_schedule.md
# present_key_schedule

Sequential PRESENT-80 key scheduler. It latches an 80-bit cipher key and iterates the key-register update 31 times. It streams the 32 resulting 64-bit round keys (K1..K32), in order, over a valid/ready interface. It sits directly upstream of the cipher round datapath, which consumes one round key per accepted handshake.

## Interface
- Parameters: none; widths and round count come from `present_pkg`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_in` in 80: cipher key, sampled only when a load is accepted.
- `key_load` in 1: load request, accepted only in IDLE.
- `busy` out 1: high in ISSUE; reset value 0.
- `rk_out` out 64: current round key, equal to key_reg[79:16]; reset value 0.
- `rk_idx` out 6: index of `rk_out`, 1..32; reset value 0.
- `rk_valid` out 1: round key valid; reset value 0.
- `rk_ready` in 1: consumer accepts `rk_out`.
- `done` out 1: one-cycle pulse after K32 is accepted; reset value 0.

## Operation
- State: `key_reg[79:0]`, `idx[5:0]`, FSM {IDLE, ISSUE}.
- IDLE:
  - `key_load`=1 → key_reg←`key_in`, idx←1, go to ISSUE.
  - Otherwise hold all state.
- ISSUE:
  - `rk_valid`=1 and `rk_out`=key_reg[79:16].
  - `rk_valid` holds while `rk_ready`=0; `rk_out` and `rk_idx` stay stable.
- Handshake (`rk_valid`&`rk_ready`) with idx<32:
  - key_reg←update(key_reg, idx[4:0]); idx←idx+1.
- Handshake with idx=32: go to IDLE, pulse `done`, hold key_reg (no 32nd update).
- Key update, in order:
  - K←K<<<61, a 61-bit left rotate of 80 bits.
  - K[79:76]←S(K[79:76]), the PRESENT 4-bit S-box.
  - K[19:15]←K[19:15]^rc, with rc=idx[4:0]∈1..31.
- `key_load` is ignored in ISSUE; no restart mid-stream.
- `key_load` on the same cycle as the final handshake is ignored; it must be reasserted in IDLE.
- `rst` mid-stream: outputs and state return to reset values immediately, and no further round keys are issued.
- `done` and `rk_valid` are never high in the same cycle.

## Timing
- Load accepted at edge N → `rk_valid`=1 with K1 after edge N.
- One round key per cycle when `rk_ready` is held high.
- Full stream: 32 cycles from first valid to last handshake.
- `done` is high in the cycle after the K32 handshake.
- `busy` deasserts in the same cycle `done` asserts.
- The next load is accepted that same cycle at the earliest.
- All outputs are registered or decoded from state only; there is no combinational path from `rk_ready` to any output.

## Structure
- `present_pkg`:
  - KEY_W=80, RK_W=64, NUM_ROUNDS=31, IDX_W=6.
  - The S-box table as a 16×4 constant, plus a `sbox4` function.
  - State enum type.
- Sub-module `present_key_update`: purely combinational, (key[79:0], rc[4:0]) → next_key[79:0].
  - Instantiated once; the FSM and registers live in the top.

## Test plan
- Zero key with `rk_ready`=1 → K1=0000000000000000, K2=C000000000000000, K3=5000180000000001; `rk_idx` reads 1,2,3.
- Zero key, full stream → exactly 32 valids, last `rk_idx`=32, `done` pulses once the following cycle, `busy` low afterwards. Encrypting with these round keys gives ciphertext 5579C1387B228445 for plaintext 0.
- Back-pressure: `rk_ready` toggled randomly → `rk_out` and `rk_idx` stable while stalled, no key skipped or duplicated.
- `key_load` pulsed with a different key during ISSUE → ignored; the stream continues with the original key.
- `rst` asserted at idx=10 → `rk_valid`, `busy` and `done` are 0 that cycle. A subsequent load of the zero key restarts at K1.
- Two back-to-back loads (second in the `done` cycle) → the second stream's K1 is valid the cycle after `done`.
